// File: rtl/logic_hc148_pending_encoder.sv
// logic_hc148_pending_encoder: registered 8-to-3 priority encoder with falling-edge pending capture and valid/ready offer
module logic_hc148_pending_encoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] ni,
    input  logic       nei,
    output logic [2:0] a,
    output logic       valid,
    input  logic       ready,
    output logic       ngs,
    output logic       neo,
    output logic       overrun,
    input  logic       clr_ovr
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;
    logic [0:0] state;
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] prev, pending, qual, clr_mask, rest;
    logic xfer, hit, load;
    logic [2:0] top;
    always_comb begin
        qual     = nei ? 8'h00 : prev & ~sync_q[SYNC_STAGES-1];
        xfer     = valid & ready;
        clr_mask = xfer ? 8'(1) << a : 8'h00;
        rest     = pending & ~clr_mask;
        hit      = |(qual & rest);
        load     = ~nei & (|rest) & ((state == IDLE) | xfer);
        top      = 3'd0;
        for (int k = 0; k < 8; k++)
            top = rest[k] ? 3'(k) : top;
    end
    // sync and prev reset to the idle level so a line held low across reset captures once
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_q  <= '1;
            prev    <= '1;
            pending <= '0;
            a       <= '0;
            overrun <= 1'b0;
            state   <= IDLE;
        end else begin
            sync_q[0] <= ni;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            prev    <= sync_q[SYNC_STAGES-1];
            pending <= qual | rest;
            overrun <= hit | (overrun & ~clr_ovr);
            if (load) begin
                a     <= top;
                state <= OFFER;
            end else if (xfer) begin
                state <= IDLE;
            end
        end
    end
    assign valid = (state == OFFER);
    assign ngs   = ~|pending;
    assign neo   = nei | (|pending);
endmodule
